sb_cfg_switch: RTL and testbench

Parametrised switch-box output stage for a CGRA tile. It routes NUM_SIDES track inputs plus the PE output onto NUM_SIDES track outputs. Each output's select field lives in a runtime-writable configuration register instead of a hard-wired constant. Each output can optionally be registered, with a stall-able pipeline register. It sits between the tile's routing tracks and the neighbouring tiles, and is programmed over the tile configuration bus.

---
 rtl/sb_cfg_switch.sv | 131 +++++++++++++
 tb/tb_sb_cfg_switch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_switch.sv
// sb_cfg_switch: CGRA tile switch-box output stage. Each of NUM_SIDES track
// outputs picks one of the other sides or the PE result through a runtime
// config register. An output can also be taken from a stall-able pipeline
// register.
// Optional feature macro: SB_PIPE_REG_EN (pipeline registers, reg_en bits, stall).
module sb_cfg_switch #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NUM_SIDES = 4,
   parameter logic [7:0]  CFG_ADDR  = 8'h00,
   parameter logic [31:0] RESET_CFG = 32'h0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       config_en,
   input  logic [7:0]                 config_addr,
   input  logic [31:0]                config_data,
   output logic [31:0]                config_rd_data,
   input  logic                       stall,
   input  logic [WIDTH-1:0]           pe_output,
   input  logic [NUM_SIDES*WIDTH-1:0] in_flat,
   output logic [NUM_SIDES*WIDTH-1:0] out_flat
);

   localparam int unsigned SEL_W    = $clog2(NUM_SIDES);
   localparam int unsigned FIELD_W  = SEL_W + 1;
   localparam int unsigned CFG_BITS = NUM_SIDES * FIELD_W;

   // Config bits that are physically stored; reg_en bits exist only with the pipeline
   function automatic logic [CFG_BITS-1:0] store_mask();
      logic [CFG_BITS-1:0] m;
      m = '0;
      for (int unsigned s = 0; s < NUM_SIDES; s++) begin
         m[s*FIELD_W +: SEL_W] = '1;
`ifdef SB_PIPE_REG_EN
         m[s*FIELD_W + SEL_W] = 1'b1;
`endif
      end
      return m;
   endfunction

   localparam logic [CFG_BITS-1:0] STORE_MASK = store_mask();

   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic                cfg_hit;
   logic [31:0]         unused_cfg_data;
   logic [WIDTH-1:0]    mux [NUM_SIDES];

   assign cfg_hit         = (config_addr == CFG_ADDR);
   assign unused_cfg_data = config_data;

   // Config next-state: load on an addressed write strobe
   always_comb begin
      cfg_d = cfg_q;
      if (config_en && cfg_hit) begin
         cfg_d = config_data[CFG_BITS-1:0] & STORE_MASK;
      end
   end

   // Config register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_q <= RESET_CFG[CFG_BITS-1:0] & STORE_MASK;
      else        cfg_q <= cfg_d;
   end

   // Read-back: zero-extended config on an address hit, zero elsewhere
   always_comb begin
      config_rd_data = '0;
      if (cfg_hit) begin
         config_rd_data[CFG_BITS-1:0] = cfg_q;
      end
   end

   // Per-side source select: k-th other side (skipping self), then PE, then zero
   always_comb begin
      int unsigned k;
      int unsigned src;
      k   = 0;
      src = 0;
      for (int unsigned s = 0; s < NUM_SIDES; s++) begin
         k      = 32'(cfg_q[s*FIELD_W +: SEL_W]);
         src    = (k < s) ? k : k + 1;
         mux[s] = '0;
         if (k < NUM_SIDES - 1) begin
            mux[s] = in_flat[src*WIDTH +: WIDTH];
         end else if (k == NUM_SIDES - 1) begin
            mux[s] = pe_output;
         end
      end
   end

`ifdef SB_PIPE_REG_EN
   logic [WIDTH-1:0] pr_q [NUM_SIDES];
   logic [WIDTH-1:0] pr_d [NUM_SIDES];

   // Pipeline next-state: track the mux every cycle (independent of reg_en) unless stalled
   always_comb begin
      for (int unsigned s = 0; s < NUM_SIDES; s++) begin
         pr_d[s] = stall ? pr_q[s] : mux[s];
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < NUM_SIDES; s++) pr_q[s] <= '0;
      end else begin
         for (int unsigned s = 0; s < NUM_SIDES; s++) pr_q[s] <= pr_d[s];
      end
   end

   // Output: registered copy where reg_en is set, raw mux elsewhere
   always_comb begin
      out_flat = '0;
      for (int unsigned s = 0; s < NUM_SIDES; s++) begin
         out_flat[s*WIDTH +: WIDTH] = cfg_q[s*FIELD_W + SEL_W] ? pr_q[s] : mux[s];
      end
   end
`else
   logic unused_stall;
   assign unused_stall = stall;

   // Output: every side is the raw mux
   always_comb begin
      out_flat = '0;
      for (int unsigned s = 0; s < NUM_SIDES; s++) begin
         out_flat[s*WIDTH +: WIDTH] = mux[s];
      end
   end
`endif

endmodule

// File: tb/tb_sb_cfg_switch.sv
// Testbench for sb_cfg_switch: two instances (4 sides at 8'h00, 3 sides at
// 8'h10 with a registered reset config) compared against a behavioural model.
module tb_sb_cfg_switch;

   localparam logic [7:0]  ADDR_A = 8'h00;
   localparam logic [7:0]  ADDR_B = 8'h10;
   localparam logic [31:0] RST_B  = 32'h0000_01F5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        config_en_a, config_en_b;
   logic [7:0]  config_addr;
   logic [31:0] config_data;
   logic        stall;
   logic [31:0] rd_a, rd_b;
   logic [15:0] pe_a, pe_b;
   logic [63:0] in_a, out_a;
   logic [47:0] in_b, out_b;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] cfg_a, cfg_b, mask_a, mask_b;
   logic [15:0] pr_a [4];
   logic [15:0] pr_b [4];

   always #5 clk = ~clk;

   sb_cfg_switch #(.WIDTH(16), .NUM_SIDES(4), .CFG_ADDR(ADDR_A), .RESET_CFG(32'h0)) dut_a (
      .clk(clk), .rst_n(rst_n), .config_en(config_en_a), .config_addr(config_addr),
      .config_data(config_data), .config_rd_data(rd_a), .stall(stall),
      .pe_output(pe_a), .in_flat(in_a), .out_flat(out_a));

   sb_cfg_switch #(.WIDTH(16), .NUM_SIDES(3), .CFG_ADDR(ADDR_B), .RESET_CFG(RST_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .config_en(config_en_b), .config_addr(config_addr),
      .config_data(config_data), .config_rd_data(rd_b), .stall(stall),
      .pe_output(pe_b), .in_flat(in_b), .out_flat(out_b));

   function automatic int unsigned sel_bits(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // Which config bits a build keeps
   function automatic logic [31:0] mk_mask(input int unsigned n);
      logic [31:0] m;
      int unsigned sw;
      sw = sel_bits(n);
      m  = '0;
      for (int unsigned s = 0; s < n; s++) begin
         m = m | (((32'd1 << sw) - 1) << (s * (sw + 1)));
`ifdef SB_PIPE_REG_EN
         m = m | (32'd1 << (s * (sw + 1) + sw));
`endif
      end
      return m;
   endfunction

   // Source for side s: list the other sides in order, then PE, else zero
   function automatic logic [15:0] ref_mux(input int unsigned n, input int unsigned s,
         input logic [31:0] cfg, input logic [63:0] ins, input logic [15:0] pe);
      int unsigned sw, k;
      int unsigned others[$];
      sw = sel_bits(n);
      k  = (cfg >> (s * (sw + 1))) & ((32'd1 << sw) - 1);
      for (int unsigned i = 0; i < n; i++) if (i != s) others.push_back(i);
      if (k < others.size()) return ins[others[k]*16 +: 16];
      if (k == n - 1) return pe;
      return 16'h0;
   endfunction

   function automatic logic [15:0] ref_out(input int unsigned n, input int unsigned s,
         input logic [31:0] cfg, input logic [63:0] ins, input logic [15:0] pe,
         input logic [15:0] pr);
      int unsigned sw;
      sw = sel_bits(n);
      if (((cfg >> (s * (sw + 1) + sw)) & 32'd1) != 0) return pr;
      return ref_mux(n, s, cfg, ins, pe);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int unsigned s = 0; s < 4; s++)
         chk($sformatf("%s a.out%0d", tag, s), {16'h0, out_a[s*16 +: 16]},
             {16'h0, ref_out(4, s, cfg_a, in_a, pe_a, pr_a[s])});
      for (int unsigned s = 0; s < 3; s++)
         chk($sformatf("%s b.out%0d", tag, s), {16'h0, out_b[s*16 +: 16]},
             {16'h0, ref_out(3, s, cfg_b, {16'h0, in_b}, pe_b, pr_b[s])});
      chk($sformatf("%s a.rd", tag), rd_a, (config_addr == ADDR_A) ? cfg_a : 32'h0);
      chk($sformatf("%s b.rd", tag), rd_b, (config_addr == ADDR_B) ? cfg_b : 32'h0);
   endtask

   task automatic model_reset();
      cfg_a = 32'h0 & mask_a;
      cfg_b = RST_B & mask_b;
      for (int unsigned s = 0; s < 4; s++) begin
         pr_a[s] = '0;
         pr_b[s] = '0;
      end
   endtask

   // One clock edge; the model samples the same pre-edge inputs the DUT sees
   task automatic tick();
      logic [15:0] nx_a [4];
      logic [15:0] nx_b [4];
      @(posedge clk);
      for (int unsigned s = 0; s < 4; s++) nx_a[s] = ref_mux(4, s, cfg_a, in_a, pe_a);
      for (int unsigned s = 0; s < 3; s++) nx_b[s] = ref_mux(3, s, cfg_b, {16'h0, in_b}, pe_b);
      if (!stall) begin
         for (int unsigned s = 0; s < 4; s++) pr_a[s] = nx_a[s];
         for (int unsigned s = 0; s < 3; s++) pr_b[s] = nx_b[s];
      end
      if (config_en_a && config_addr == ADDR_A) cfg_a = config_data & mask_a;
      if (config_en_b && config_addr == ADDR_B) cfg_b = config_data & mask_b;
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      config_addr = addr;
      config_data = data;
      config_en_a = 1'b1;
      config_en_b = 1'b1;
      tick();
      config_en_a = 1'b0;
      config_en_b = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_tbl [4];
      int unsigned r;
      exp_tbl = '{16'h0001, 16'h0002, 16'h0003, 16'h00FF};
      mask_a  = mk_mask(4);
      mask_b  = mk_mask(3);
      rst_n = 1'b1;
      config_en_a = 1'b0;
      config_en_b = 1'b0;
      config_addr = ADDR_A;
      config_data = '0;
      stall = 1'b0;
      in_a = {$urandom, $urandom};
      in_b = 48'({$urandom, $urandom});
      pe_a = 16'($urandom);
      pe_b = 16'($urandom);

      // Asynchronous reset, observed before any clock edge
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("reset");
      chk("reset rd_a", rd_a, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_all("post_reset");

      // Exhaustive select on side 1, combinational
      in_a = {16'h0003, 16'h0002, 16'($urandom), 16'h0001};
      pe_a = 16'h00FF;
      for (int unsigned k = 0; k < 4; k++) begin
         wr(ADDR_A, 32'(k) << 3);
         chk($sformatf("sel side1 k=%0d", k), {16'h0, out_a[31:16]}, {16'h0, exp_tbl[k]});
         check_all("sel");
      end

      // Registered path on side 0 (pe, reg_en)
      wr(ADDR_A, 32'h0000_0007);
      check_all("reg_cfg");
      for (int unsigned v = 1; v <= 3; v++) begin
         pe_a = 16'(v);
         #1 check_all("reg_pre");
         tick();
         check_all("reg_post");
      end
      stall = 1'b1;
      pe_a = 16'h0004;
      tick();
      check_all("stall1");
      pe_a = 16'h0005;
      tick();
      check_all("stall2");
      stall = 1'b0;
      tick();
      check_all("unstall");

      // Config write during stall: write lands, pipeline holds
      stall = 1'b1;
      pe_a = 16'h0006;
      wr(ADDR_A, 32'h0000_000F);
      stall = 1'b0;
      chk("wr_stall rd", rd_a, 32'h0000_000F & mask_a);
      check_all("wr_stall");

      // Address decode
      wr(8'h01, 32'hFFFF_FFFF);
      chk("miss rd", rd_a, 32'h0);
      config_addr = ADDR_A;
      #1 chk("miss unchanged", rd_a, 32'h0000_000F & mask_a);
      wr(ADDR_A, 32'hFFFF_FFFF);
`ifdef SB_PIPE_REG_EN
      chk("hit rd", rd_a, 32'h0000_0FFF);
`else
      chk("hit rd", rd_a, 32'h0000_06DB);
`endif
      check_all("hit");

      // Randomised traffic
      for (int unsigned i = 0; i < 60; i++) begin
         in_a = {$urandom, $urandom};
         in_b = 48'({$urandom, $urandom});
         pe_a = 16'($urandom);
         pe_b = 16'($urandom);
         r = $urandom_range(0, 3);
         config_addr = (r == 0) ? ADDR_A : (r == 1) ? ADDR_B : 8'h55;
         config_data = $urandom;
         config_en_a = (r != 3);
         config_en_b = (r != 3);
         stall = ($urandom_range(0, 3) == 0);
         tick();
         check_all("rand_edge");
         in_a = {$urandom, $urandom};
         in_b = 48'({$urandom, $urandom});
         pe_a = 16'($urandom);
         config_addr = ($urandom_range(0, 1) == 0) ? ADDR_A : ADDR_B;
         #1 check_all("rand_comb");
      end
      config_en_a = 1'b0;
      config_en_b = 1'b0;
      stall = 1'b0;

      // Three-side instance: out-of-range select gives 0, sel 2 gives PE
      wr(ADDR_B, 32'h0000_00C0);
      chk("b side2 sel3", {16'h0, out_b[47:32]}, 32'h0);
      check_all("b_sel3");
      wr(ADDR_B, 32'h0000_0080);
      chk("b side2 sel2", {16'h0, out_b[47:32]}, {16'h0, pe_b});
      check_all("b_sel2");

      // Reset in the middle of registered traffic
      wr(ADDR_A, 32'hFFFF_FFFF);
      pe_a = 16'h1234;
      tick();
      check_all("pre_midreset");
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("midreset");
      chk("midreset rd_a", rd_a, (config_addr == ADDR_A) ? 32'h0 : rd_a ^ rd_a);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_all("after_midreset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
